// File: rtl/mult_hazard_scoreboard_if.sv
// rtl/mult_hazard_scoreboard_if.sv - ID-stage decode fields in, stall request and status out
interface mult_hazard_scoreboard_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic             id_flush;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_is_mult;
  logic             id_is_load;
  logic             stall;
  logic [1:0]       stall_cause;
  logic             pending_any;

  modport master (
    output id_valid, id_flush, id_rs1, id_rs2, id_use_rs2, id_rd,
           id_reg_write, id_is_mult, id_is_load,
    input  stall, stall_cause, pending_any
  );

  modport slave (
    input  id_valid, id_flush, id_rs1, id_rs2, id_use_rs2, id_rd,
           id_reg_write, id_is_mult, id_is_load,
    output stall, stall_cause, pending_any
  );
endinterface

// File: rtl/mult_hazard_scoreboard.sv
// rtl/mult_hazard_scoreboard.sv - per-register countdown scoreboard raising ID stalls on RAW/WAW
module mult_hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int MULT_LAT = 3,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 2
) (
  input logic                     clk,
  input logic                     arst_n,
  mult_hazard_scoreboard_if.slave id
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic [CNT_W-1:0] new_lat;
  logic             raw1, raw2, waw, issue, pending_next;

  // Cycles until the incoming result is forwardable; ALU results need none.
  always_comb begin
    new_lat = '0;
    if (id.id_is_mult)      new_lat = CNT_W'(MULT_LAT - 1);
    else if (id.id_is_load) new_lat = CNT_W'(LOAD_LAT - 1);
  end

  always_comb begin
    raw1 = id.id_valid && (id.id_rs1 != '0) && (cnt[id.id_rs1] != '0);
    raw2 = id.id_valid && id.id_use_rs2 && (id.id_rs2 != '0) && (cnt[id.id_rs2] != '0);
    waw  = id.id_valid && id.id_reg_write && (id.id_rd != '0) && (cnt[id.id_rd] > new_lat);
    id.stall = (raw1 || raw2 || waw) && !id.id_flush;
    issue    = id.id_valid && !id.id_flush && !id.stall;
  end

  always_comb begin
    id.stall_cause = 2'b00;
    if (id.stall) begin
      if (raw1)      id.stall_cause = 2'b01;
      else if (raw2) id.stall_cause = 2'b10;
      else           id.stall_cause = 2'b11;
    end
  end

  always_comb begin
    pending_next = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_next[r] = (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
      if (issue && id.id_reg_write && (id.id_rd == REG_W'(r)))
        cnt_next[r] = new_lat;
      // x0 is never tracked, so its entry stays zero regardless of issue.
      if (r == 0)
        cnt_next[r] = '0;
      pending_next = pending_next || (cnt_next[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      id.pending_any <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_next[r];
      id.pending_any <= pending_next;
    end
  end
endmodule
